// File: rtl/trace_pkg.sv
// Shared types and entry layout for the retire-trace buffer.
// The beat count depends on the TRACE_TIMESTAMP_EN build macro.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [1:0] BEAT_INSTR = 2'd0;
  localparam logic [1:0] BEAT_ALU   = 2'd1;
  localparam logic [1:0] BEAT_BUSW  = 2'd2;

`ifdef TRACE_TIMESTAMP_EN
  localparam logic [1:0] BEAT_TS = 2'd3;
  localparam int         BEATS   = 4;
`else
  localparam int         BEATS   = 3;
`endif

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam int         ENTRY_W   = 32 * BEATS;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrapping pointers and an occupancy count.
// A push while full or a pop while empty is ignored.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the pre-edge count, so a same-cycle pop never frees room for a push.
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trace_buffer.sv
// Retire-trace capture: samples processor outputs into a FIFO and drains them as 32-bit beats.
// Build macro TRACE_TIMESTAMP_EN appends a capture-cycle timestamp beat to each entry.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          DROP_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic [31:0]              instruction,
  input  logic [31:0]              busW,
  input  logic [31:0]              aluresult,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     capturing,
  output logic                     stopped,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  state_t             state;
  state_t             state_nx;
  logic [1:0]         beat;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               capture;
  logic               drop;
  logic               accept;
  logic               pop;

  assign capture   = (state == ARMED);
  assign drop      = capture && fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = out_valid && out_ready;
  assign pop       = accept && (beat == LAST_BEAT);
  assign capturing = (state == ARMED);
  assign stopped   = (state == STOPPED);
  assign out_last  = out_valid && (beat == LAST_BEAT);
  assign out_data  = out_valid ? head[32*beat +: 32] : 32'd0;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] timestamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       timestamp <= '0;
    else if (arm)     timestamp <= '0;
    else if (capture) timestamp <= timestamp + 32'd1;
  end
`endif

  always_comb begin
    entry = '0;
    entry[32*BEAT_INSTR +: 32] = instruction;
    entry[32*BEAT_ALU   +: 32] = aluresult;
    entry[32*BEAT_BUSW  +: 32] = busW;
`ifdef TRACE_TIMESTAMP_EN
    entry[32*BEAT_TS    +: 32] = timestamp;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A re-arm while capturing takes priority over a halt seen in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = ARMED;
      ARMED:   if (!arm && instruction == HALT_WORD) state_nx = STOPPED;
      STOPPED: if (arm) state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat <= '0;
    else if (accept) beat <= (beat == LAST_BEAT) ? 2'd0 : beat + 2'd1;
  end

  // Arm wins over a drop in the same cycle so the counters always restart at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (arm) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  trace_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (pop),
    .din   (entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head),
    .level (level)
  );

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=8, default halt word).
module tb_trace_buffer;

  localparam int          DEPTH  = 8;
  localparam int          DROP_W = 8;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TB_BEATS = 4;
`else
  localparam int TB_BEATS = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arm;
  logic [31:0]       instruction;
  logic [31:0]       busW;
  logic [31:0]       aluresult;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              capturing;
  logic              stopped;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic [3:0]        level;

  int checks = 0;
  int errors = 0;

  trace_buffer #(.DEPTH(DEPTH), .HALT_WORD(HALT), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .instruction(instruction), .busW(busW),
    .aluresult(aluresult), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .capturing(capturing), .stopped(stopped), .overflow(overflow),
    .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; out_ready = 1'b0;
    instruction = '0; busW = '0; aluresult = '0;
    #3;
    checks++;
    if ({out_valid, out_last, capturing, stopped, overflow} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {out_valid, out_last, capturing, stopped, overflow});
    end
    checks++;
    if (level !== 4'd0 || drop_cnt !== 8'd0 || out_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got level=%0d drop=%0d data=%h expected 0/0/0", level, drop_cnt, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture_drain();
    logic [31:0] vi [3];
    logic [31:0] vv [3];
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic [31:0] got_d [$];
    logic        got_l [$];
    logic [3:0]  peak;
    vi = '{32'h0000_0020, 32'h0000_0024, HALT};
    vv = '{32'd5, 32'd6, 32'd7};
    for (int k = 0; k < 3; k++) begin
      exp_d.push_back(vi[k]); exp_l.push_back(1'b0);
      exp_d.push_back(vv[k]); exp_l.push_back(1'b0);
      exp_d.push_back(vv[k]); exp_l.push_back(TB_BEATS == 3);
      if (TB_BEATS == 4) begin
        exp_d.push_back(32'(k)); exp_l.push_back(1'b1);
      end
    end
    peak = '0;
    out_ready = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c < 3) begin
        instruction = vi[c]; aluresult = vv[c]; busW = vv[c];
      end else begin
        instruction = '0; aluresult = '0; busW = '0;
      end
      if (out_valid) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      tick();
      if (level > peak) peak = level;
      if (c == 2) begin
        checks++;
        if (stopped !== 1'b1) begin
          errors++;
          $display("[TB] FAIL cd_stopped: got %b expected 1", stopped);
        end
      end
    end
    checks++;
    if (peak !== 4'd3) begin
      errors++;
      $display("[TB] FAIL cd_level_peak: got %0d expected 3", peak);
    end
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL cd_beat_count: got %0d expected %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("[TB] FAIL cd_beat%0d: got data=%h last=%b expected data=%h last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    instruction = HALT; aluresult = 32'h0000_00AA; busW = 32'h0000_00BB;
    tick();
    instruction = '0; aluresult = '0; busW = '0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, HALT}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b last=%b data=%h expected 1/0/%h",
                 i, out_valid, out_last, out_data, HALT);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 32'h0000_00AA) begin
      errors++;
      $display("[TB] FAIL bp_beat1: got %h expected 000000aa", out_data);
    end
    tick();
    checks++;
    if (out_data !== 32'h0000_00BB || out_last !== (TB_BEATS == 3)) begin
      errors++;
      $display("[TB] FAIL bp_beat2: got data=%h last=%b expected 000000bb/%b", out_data, out_last, TB_BEATS == 3);
    end
    for (int i = 0; i < 5 && out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL bp_drained: got valid=%b level=%0d expected 0/0", out_valid, level);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 11; i++) begin
      instruction = 32'h100 + 32'(i); aluresult = 32'h200 + 32'(i); busW = 32'h300 + 32'(i);
      tick();
    end
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd3) begin
      errors++;
      $display("[TB] FAIL ov_full: got level=%0d ovf=%b drop=%0d expected 8/1/3", level, overflow, drop_cnt);
    end
    arm = 1'b1;
    instruction = 32'h10B;
    tick();
    arm = 1'b0;
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0 || capturing !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ov_rearm: got level=%0d ovf=%b drop=%0d cap=%b expected 8/0/0/1",
               level, overflow, drop_cnt, capturing);
    end
    instruction = HALT;
    tick();
    instruction = '0;
    checks++;
    if (stopped !== 1'b1 || drop_cnt !== 8'd1 || level !== 4'd8) begin
      errors++;
      $display("[TB] FAIL ov_halt_dropped: got stop=%b drop=%0d level=%0d expected 1/1/8", stopped, drop_cnt, level);
    end
  endtask

  task automatic test_full_pop();
    arm = 1'b1;
    instruction = 32'h400;
    tick();
    arm = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < TB_BEATS - 1; b++) tick();
    checks++;
    if (drop_cnt !== 8'(TB_BEATS - 1) || level !== 4'd8) begin
      errors++;
      $display("[TB] FAIL fp_before: got drop=%0d level=%0d expected %0d/8", drop_cnt, level, TB_BEATS - 1);
    end
    instruction = HALT;
    tick();
    out_ready = 1'b0;
    instruction = '0;
    checks++;
    if (level !== 4'd7 || drop_cnt !== 8'(TB_BEATS) || stopped !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fp_no_bypass: got level=%0d drop=%0d stop=%b expected 7/%0d/1",
               level, drop_cnt, stopped, TB_BEATS);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h101) begin
      errors++;
      $display("[TB] FAIL fp_head: got valid=%b data=%h expected 1/00000101", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_data !== 32'h201) begin
      errors++;
      $display("[TB] FAIL rm_beat1: got %h expected 00000201", out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, capturing, stopped, overflow} !== 4'b0 || level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL rm_async: got valid=%b cap=%b stop=%b ovf=%b level=%0d expected all 0",
               out_valid, capturing, stopped, overflow, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rm_after: got valid=%b data=%h expected 0/0", out_valid, out_data);
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] got_d [$];
    logic        got_l [$];
    out_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instruction = (i == 3) ? HALT : 32'h500 + 32'(i);
      aluresult = 32'h600 + 32'(i); busW = 32'h700 + 32'(i);
      tick();
    end
    instruction = '0;
    checks++;
    if (stopped !== 1'b1 || level !== 4'd4) begin
      errors++;
      $display("[TB] FAIL ts_stop: got stop=%b level=%0d expected 1/4", stopped, level);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      tick();
    end
    checks++;
    if (got_d.size() != 16) begin
      errors++;
      $display("[TB] FAIL ts_beat_count: got %0d expected 16", got_d.size());
    end else begin
      checks++;
      if (got_d[12] !== HALT || got_d[15] !== 32'd3 || got_l[15] !== 1'b1 || got_l[14] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ts_halt_entry: got instr=%h ts=%h last3=%b last2=%b expected %h/3/1/0",
                 got_d[12], got_d[15], got_l[15], got_l[14], HALT);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_capture_drain();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid_drain();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Retire-trace capture stage directly downstream of the single-cycle processor top.
- Samples the processor's per-cycle outputs each clock: instruction, busW and aluresult.
- Buffers each sample as one entry in an on-chip FIFO and drains it to a host over a 32-bit valid/ready stream, one word per beat.
- Capture is armed by the host and stops on a halt instruction, so a full program run can be dumped after the fact.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that ends capture.
- DROP_W, 8, width of the saturating dropped-entry counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse; start or restart capture.
- instruction  in  32  retired instruction from the processor.
- busW  in  32  register-file write data from the processor.
- aluresult  in  32  ALU result from the processor.
- out_valid  out  1  out_data holds a valid trace word.
- out_ready  in  1  host accepts the word.
- out_data  out  32  current trace word.
- out_last  out  1  current beat is the final beat of its entry.
- capturing  out  1  state == ARMED.
- stopped  out  1  state == STOPPED.
- overflow  out  1  sticky flag; at least one entry was dropped.
- drop_cnt  out  DROP_W  number of dropped entries, saturating.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, beat index 0, timestamp 0. All outputs 0; out_data = 0 when empty. Reset mid-drain discards the partial entry.
- States:
  - IDLE: no capture. arm -> ARMED.
  - ARMED: push one entry every cycle. instruction == HALT_WORD -> STOPPED; the halt entry itself is pushed if space exists.
  - STOPPED: no capture. arm -> ARMED.
  - arm while ARMED: stays ARMED and still captures that cycle.
- Arm side effects: arm clears overflow and drop_cnt. FIFO contents are preserved; arm never flushes.
- Entry layout, in beat order:
  - beat 0 = instruction
  - beat 1 = aluresult
  - beat 2 = busW
- Push rule:
  - Full is evaluated on the pre-edge occupancy. A push while full is dropped even if a pop completes the same cycle; there is no bypass.
  - A dropped push sets overflow and increments drop_cnt, saturating at all-ones.
- Drain:
  - out_valid = level != 0. out_data is selected from the FIFO head by beat index.
  - Beat advances on out_valid && out_ready.
  - Acceptance of the last beat pops the entry and returns the beat index to 0.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Latency: an entry sampled at edge N has out_valid high after edge N (cycle N+1) if the FIFO was empty.
- Level: push only +1; pop only -1; simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- Draining is allowed in every state, including during capture.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit cycle counter is cleared on arm and increments each ARMED cycle, wrapping.
  - Each entry gains beat 3 = counter value at capture; beats per entry = 4, out_last on beat 3.
- Undefined: no counter; beats per entry = 3, out_last on beat 2.

Decomposition:
- Package trace_pkg holds:
  - state encoding IDLE/ARMED/STOPPED;
  - beat index constants and BEATS, conditional on the macro;
  - entry width localparam.
- Sub-module trace_fifo: synchronous FIFO with ptr-wrap and level logic, parameterised by width and depth.
- Serializer and FSM stay in trace_buffer.

Test Plan:
- Capture and drain:
  - Stimulus: reset, arm, three cycles with instruction 32'h0000_0020 / 32'h0000_0024 / HALT_WORD, aluresult 5/6/7, busW 5/6/7, out_ready=1.
  - Required: stopped=1 after edge 3; level peaks at 3; 9 beats out, in order 00000020,5,5,00000024,6,6,FFFFFFFF,7,7; out_last on beats 3, 6 and 9.
- Backpressure:
  - Stimulus: one entry buffered, out_ready=0 for 5 cycles, then 1.
  - Required: out_data = instruction, stable, for all 5 cycles; beat 1 appears one cycle after ready rises.
- Overflow:
  - Stimulus: DEPTH=8, arm, 11 capture cycles without HALT_WORD, out_ready=0.
  - Required: level=8, overflow=1, drop_cnt=3; re-arm clears overflow and drop_cnt, level stays 8.
- Full with simultaneous pop:
  - Stimulus: FIFO full and the last beat accepted in the same cycle as a capture.
  - Required: the new entry is dropped, level=7, drop_cnt increments.
- Reset mid-drain:
  - Stimulus: rst_n low after beat 1 of an entry.
  - Required: out_valid=0, level=0 and state IDLE immediately, without waiting for a clock edge.
- Timestamp (TRACE_TIMESTAMP_EN defined):
  - Stimulus: arm, then HALT_WORD on the 4th ARMED cycle.
  - Required: the halt entry's beat 3 = 3 and out_last asserts on beat 4.
